// File: rtl/fetch_aligner_pkg.sv
// fetch_pkg: shared types and constants for the fetch aligner slice.
// Holds the sequencer state encoding and instruction width constants.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int HW_W    = 16;

    localparam logic [1:0] OPC_32B = 2'b11;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        SPLIT,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_aligner_decompress.sv
// decompress: combinational RV32C to RV32I expander.
// Input is a zero-extended halfword; anything unrecognised expands to 0.
module decompress
    import fetch_pkg::*;
(
    input  logic [INSTR_W-1:0] cinstr,
    output logic [INSTR_W-1:0] instr
);

    logic [HW_W-1:0]    c;
    logic [4:0]         rd;
    logic [4:0]         rs2;
    logic [4:0]         rdp;
    logic [4:0]         rs2p;
    logic [10:0]        jo;
    logic [2:0]         alu_f3;
    logic [6:0]         alu_f7;
    logic [INSTR_W-1:0] exp_i;

    assign c    = cinstr[HW_W-1:0];
    assign rd   = c[11:7];
    assign rs2  = c[6:2];
    assign rdp  = {2'b01, c[9:7]};
    assign rs2p = {2'b01, c[4:2]};
    // c.j / c.jal offset bits [11:1]
    assign jo   = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};

    always_comb begin
        alu_f3 = 3'b111;
        alu_f7 = 7'b0000000;
        case (c[6:5])
            2'b00:   begin alu_f3 = 3'b000; alu_f7 = 7'b0100000; end
            2'b01:   alu_f3 = 3'b100;
            2'b10:   alu_f3 = 3'b110;
            default: alu_f3 = 3'b111;
        endcase
    end

    always_comb begin
        exp_i = '0;
        case ({c[1:0], c[15:13]})
            5'b00_000: exp_i = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00,
                                5'd2, 3'b000, rs2p, 7'h13};
            5'b00_010: exp_i = {5'b0, c[5], c[12:10], c[6], 2'b00,
                                rdp, 3'b010, rs2p, 7'h03};
            5'b00_110: exp_i = {5'b0, c[5], c[12], rs2p, rdp, 3'b010,
                                c[11:10], c[6], 2'b00, 7'h23};
            5'b01_000: exp_i = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h13};
            5'b01_001: exp_i = {jo[10], jo[9:0], jo[10], {8{jo[10]}},
                                5'd1, 7'h6f};
            5'b01_010: exp_i = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'h13};
            5'b01_011: begin
                if (rd == 5'd2)
                    exp_i = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000,
                             5'd2, 3'b000, 5'd2, 7'h13};
                else
                    exp_i = {{15{c[12]}}, c[6:2], rd, 7'h37};
            end
            5'b01_100: begin
                case (c[11:10])
                    2'b00:   exp_i = {7'b0000000, c[6:2], rdp, 3'b101, rdp, 7'h13};
                    2'b01:   exp_i = {7'b0100000, c[6:2], rdp, 3'b101, rdp, 7'h13};
                    2'b10:   exp_i = {{7{c[12]}}, c[6:2], rdp, 3'b111, rdp, 7'h13};
                    default: exp_i = {alu_f7, rs2p, rdp, alu_f3, rdp, 7'h33};
                endcase
            end
            5'b01_101: exp_i = {jo[10], jo[9:0], jo[10], {8{jo[10]}},
                                5'd0, 7'h6f};
            5'b01_110: exp_i = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rdp,
                                3'b000, c[11:10], c[4:3], c[12], 7'h63};
            5'b01_111: exp_i = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rdp,
                                3'b001, c[11:10], c[4:3], c[12], 7'h63};
            5'b10_000: exp_i = {7'b0, c[6:2], rd, 3'b001, rd, 7'h13};
            5'b10_010: exp_i = {4'b0, c[3:2], c[12], c[6:4], 2'b00,
                                5'd2, 3'b010, rd, 7'h03};
            5'b10_100: begin
                if (!c[12])
                    exp_i = (rs2 == 5'd0)
                          ? {12'b0, rd, 3'b000, 5'd0, 7'h67}
                          : {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
                else if (rs2 != 5'd0)
                    exp_i = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
                else if (rd == 5'd0)
                    exp_i = 32'h0010_0073;
                else
                    exp_i = {12'b0, rd, 3'b000, 5'd1, 7'h67};
            end
            5'b10_110: exp_i = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010,
                                c[11:9], 2'b00, 7'h23};
            default:   exp_i = '0;
        endcase
    end

    assign instr = (cinstr[INSTR_W-1:HW_W] == '0) ? exp_i : '0;

endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: word fetch sequencer and halfword aligner for the decoder.
// Define FETCH_RVC_EN to build compressed-instruction support.
module fetch_aligner
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    output logic               ic_req_valid,
    output logic [31:0]        ic_req_addr,
    input  logic               ic_req_ready,
    input  logic               ic_resp_valid,
    input  logic [31:0]        ic_resp_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [31:0]        dec_pc,
    output logic               dec_is_c
);

    fetch_state_e       state;
    fetch_state_e       state_n;
    logic [31:0]        pc;
    logic [31:0]        pc_n;
    logic [31:0]        wbuf;
    logic [31:0]        wbuf_n;
    logic               drop;
    logic               drop_n;
    logic               emit;
    logic [INSTR_W-1:0] emit_instr;
    logic [31:0]        req_addr_n;
    logic               slot_free;
    logic               req_fire;
    logic               unused_rpc;

    assign slot_free = !dec_valid || dec_ready;
    assign req_fire  = (state == FETCH) && ic_req_valid && ic_req_ready;

`ifdef FETCH_RVC_EN
    logic [HW_W-1:0]    hw;
    logic [HW_W-1:0]    hw_n;
    logic               hw_valid;
    logic               hw_valid_n;
    logic               emit_c;
    logic [INSTR_W-1:0] dc_in;
    logic [INSTR_W-1:0] dc_out;

    assign dc_in = {{(INSTR_W-HW_W){1'b0}},
                    (state == HOLD) ? hw : wbuf[HW_W-1:0]};

    decompress u_decompress (
        .cinstr (dc_in),
        .instr  (dc_out)
    );

    assign unused_rpc = redirect_pc[0];
    // a buffered halfword means the next word to fetch is past it
    assign req_addr_n = {pc_n[31:2] + {29'b0, hw_valid_n}, 2'b00};
`else
    assign unused_rpc = ^redirect_pc[1:0];
    assign req_addr_n = {pc_n[31:2], 2'b00};
    assign dec_is_c   = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        wbuf_n     = wbuf;
        drop_n     = drop;
        emit       = 1'b0;
        emit_instr = wbuf;
`ifdef FETCH_RVC_EN
        hw_n       = hw;
        hw_valid_n = hw_valid;
        emit_c     = 1'b0;
`endif
        case (state)
            FETCH: begin
                if (drop && ic_resp_valid)
                    drop_n = 1'b0;
                if (req_fire)
                    state_n = WAIT;
            end
            WAIT: begin
                if (ic_resp_valid) begin
                    wbuf_n  = ic_resp_data;
                    state_n = SPLIT;
                end
            end
            SPLIT: begin
                if (slot_free) begin
`ifdef FETCH_RVC_EN
                    if (hw_valid) begin
                        emit       = 1'b1;
                        emit_instr = {wbuf[HW_W-1:0], hw};
                        pc_n       = pc + 32'd4;
                        hw_n       = wbuf[31:16];
                        state_n    = HOLD;
                    end else if (!pc[1]) begin
                        emit = 1'b1;
                        if (wbuf[1:0] != OPC_32B) begin
                            emit_instr = dc_out;
                            emit_c     = 1'b1;
                            pc_n       = pc + 32'd2;
                            hw_n       = wbuf[31:16];
                            hw_valid_n = 1'b1;
                            state_n    = HOLD;
                        end else begin
                            pc_n    = pc + 32'd4;
                            state_n = FETCH;
                        end
                    end else begin
                        hw_n       = wbuf[31:16];
                        hw_valid_n = 1'b1;
                        state_n    = HOLD;
                    end
`else
                    emit    = 1'b1;
                    pc_n    = pc + 32'd4;
                    state_n = FETCH;
`endif
                end
            end
`ifdef FETCH_RVC_EN
            HOLD: begin
                if (hw[1:0] == OPC_32B) begin
                    state_n = FETCH;
                end else if (slot_free) begin
                    emit       = 1'b1;
                    emit_instr = dc_out;
                    emit_c     = 1'b1;
                    pc_n       = pc + 32'd2;
                    hw_valid_n = 1'b0;
                    state_n    = FETCH;
                end
            end
`endif
            default: state_n = FETCH;
        endcase

        if (redirect_valid) begin
            state_n = FETCH;
            drop_n  = ((state == WAIT) && !ic_resp_valid) || req_fire
                    || (drop && !ic_resp_valid);
`ifdef FETCH_RVC_EN
            pc_n       = {redirect_pc[31:1], 1'b0};
            hw_valid_n = 1'b0;
`else
            pc_n       = {redirect_pc[31:2], 2'b00};
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            wbuf         <= '0;
            drop         <= 1'b0;
            ic_req_valid <= 1'b0;
            ic_req_addr  <= '0;
            dec_valid    <= 1'b0;
            dec_instr    <= '0;
            dec_pc       <= '0;
`ifdef FETCH_RVC_EN
            hw           <= '0;
            hw_valid     <= 1'b0;
            dec_is_c     <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            wbuf         <= wbuf_n;
            drop         <= drop_n;
            ic_req_valid <= (state_n == FETCH) && !drop_n;
            ic_req_addr  <= req_addr_n;
`ifdef FETCH_RVC_EN
            hw           <= hw_n;
            hw_valid     <= hw_valid_n;
`endif
            if (redirect_valid) begin
                dec_valid <= 1'b0;
            end else if (emit) begin
                dec_valid <= 1'b1;
                dec_instr <= emit_instr;
                dec_pc    <= pc;
`ifdef FETCH_RVC_EN
                dec_is_c  <= emit_c;
`endif
            end else if (dec_ready) begin
                dec_valid <= 1'b0;
            end
        end
    end

endmodule
